// File: rtl/shift_seq_pkg.sv
// -----------------------------------------------------------------------------
// shift_seq_pkg
// Shared definitions for the serial shift-register sequencer:
//   - state_t   : FSM state encoding (IDLE=0, SHIFT=1, LATCH=2, GAP=3)
//   - DEF_*     : default parameter values used by shift_seq_ctrl
//   - clog2_min1: $clog2 that never returns less than 1, so counters that only
//                 ever need zero bits still get a legal one-bit vector
// -----------------------------------------------------------------------------
package shift_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam int DEF_WIDTH      = 16;
    localparam int DEF_CLK_DIV    = 4;
    localparam int DEF_GAP_CYCLES = 2;

    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/shift_tick_gen.sv
// -----------------------------------------------------------------------------
// shift_tick_gen
// Bit-rate divider for the shift sequencer. Owns div_cnt and produces the
// registered per-bit strobe (tick), high in the cycle where div_cnt is at its
// terminal value CLK_DIV-1.
//
// Ports:
//   CLK   in  system clock, rising edge
//   RST   in  asynchronous reset, active-high
//   clear in  restart: the next cycle is the first divider cycle (div_cnt=0)
//   run   in  continue counting into the next cycle; when neither clear nor
//             run is high the divider parks at 0 with tick low
//   tick  out registered strobe, one cycle per serial bit
// -----------------------------------------------------------------------------
module shift_tick_gen
    import shift_seq_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int DW = clog2_min1(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt_reg;
    logic [DW-1:0] div_cnt_next;
    logic          tick_reg;
    logic          tick_next;

    // The strobe is computed from the count the *next* cycle will hold, so
    // that tick_reg is high exactly during the cycle where div_cnt==CLK_DIV-1.
    always_comb begin
        div_cnt_next = '0;
        tick_next    = 1'b0;
        if (clear) begin
            div_cnt_next = '0;
            tick_next    = (DIV_LAST == '0);
        end else if (run) begin
            div_cnt_next = (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + DW'(1);
            tick_next    = (div_cnt_next == DIV_LAST);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_cnt_reg <= '0;
            tick_reg    <= 1'b0;
        end else begin
            div_cnt_reg <= div_cnt_next;
            tick_reg    <= tick_next;
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl
// Sequencer for the serial shift-register chain. Takes a parallel word over a
// VALID/READY handshake, shifts it out on SDATA inside the ENdin window with
// one SHIFT_STB per bit, pulses LATCH/DONE after the last bit and then holds
// off for GAP_CYCLES before accepting the next word.
//
// Ports:
//   CLK        in  system clock, rising edge
//   RST        in  asynchronous reset, active-high
//   DATA_IN    in  [WIDTH] word to serialize
//   VALID      in  DATA_IN valid
//   READY      out block can accept a word (decode of state==IDLE)
//   ABORT      in  synchronous frame cancel, honoured in SHIFT and LATCH
//   SDATA      out serial data bit (registered)
//   SHIFT_STB  out one-cycle strobe; chain samples SDATA on it (registered)
//   ENdin      out high for the whole shift window (registered)
//   LATCH      out one-cycle parallel-latch pulse after the last bit
//   BUSY       out state != IDLE (registered)
//   DONE       out one-cycle pulse, same cycle as LATCH
//
// Build option: define SHIFT_SEQ_LSB_FIRST_EN to send the word LSB first;
// by default it is sent MSB first. Timing is identical either way.
// -----------------------------------------------------------------------------
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             VALID,
    output logic             READY,
    input  logic             ABORT,
    output logic             SDATA,
    output logic             SHIFT_STB,
    output logic             ENdin,
    output logic             LATCH,
    output logic             BUSY,
    output logic             DONE
);

    localparam int BW = clog2_min1(WIDTH);
    localparam int GW = clog2_min1(GAP_CYCLES + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state_reg;
    logic [WIDTH-1:0] shadow_reg;
    logic [BW-1:0]    bit_cnt_reg;
    logic [GW-1:0]    gap_cnt_reg;
    logic             sdata_reg;
    logic             endin_reg;
    logic             latch_reg;
    logic             done_reg;
    logic             busy_reg;

    logic             tick;
    logic             tick_clear;
    logic             tick_run;
    logic             last_strobe;
    logic             first_bit;
    logic [BW-1:0]    bit_cnt_next;
    logic [WIDTH-1:0] ser_order;

    // ser_order[i] is the shadow bit that goes out as the i-th serial bit, so
    // the datapath below never needs to know the bit order.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
`ifdef SHIFT_SEQ_LSB_FIRST_EN
            assign ser_order[gi] = shadow_reg[gi];
`else
            assign ser_order[gi] = shadow_reg[WIDTH-1-gi];
`endif
        end
    endgenerate

    // The first bit is registered in the accept cycle, before the shadow
    // register holds the word, so it is taken straight from DATA_IN.
`ifdef SHIFT_SEQ_LSB_FIRST_EN
    assign first_bit = DATA_IN[0];
`else
    assign first_bit = DATA_IN[WIDTH-1];
`endif

    assign bit_cnt_next = bit_cnt_reg + BW'(1);
    assign last_strobe  = tick && (bit_cnt_reg == BIT_LAST);

    // The divider restarts on accept and keeps running only while the frame
    // stays in SHIFT; an abort or the final strobe parks it, which is what
    // suppresses any further SHIFT_STB.
    assign tick_clear = (state_reg == ST_IDLE) && VALID;
    assign tick_run   = (state_reg == ST_SHIFT) && !ABORT && !last_strobe;

    shift_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .CLK   (CLK),
        .RST   (RST),
        .clear (tick_clear),
        .run   (tick_run),
        .tick  (tick)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg   <= ST_IDLE;
            shadow_reg  <= '0;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            sdata_reg   <= 1'b0;
            endin_reg   <= 1'b0;
            latch_reg   <= 1'b0;
            done_reg    <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            // LATCH and DONE are single-cycle pulses unless re-armed below.
            latch_reg <= 1'b0;
            done_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (VALID) begin
                        state_reg   <= ST_SHIFT;
                        shadow_reg  <= DATA_IN;
                        bit_cnt_reg <= '0;
                        sdata_reg   <= first_bit;
                        endin_reg   <= 1'b1;
                        busy_reg    <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // Abort takes priority over the final strobe, so a
                    // cancelled frame never produces a LATCH.
                    if (ABORT) begin
                        state_reg   <= ST_IDLE;
                        bit_cnt_reg <= '0;
                        sdata_reg   <= 1'b0;
                        endin_reg   <= 1'b0;
                        busy_reg    <= 1'b0;
                    end else if (last_strobe) begin
                        state_reg   <= ST_LATCH;
                        bit_cnt_reg <= '0;
                        sdata_reg   <= 1'b0;
                        endin_reg   <= 1'b0;
                        latch_reg   <= 1'b1;
                        done_reg    <= 1'b1;
                    end else if (tick) begin
                        bit_cnt_reg <= bit_cnt_next;
                        sdata_reg   <= ser_order[bit_cnt_next];
                    end
                end
                ST_LATCH: begin
                    if (ABORT || (GAP_CYCLES == 0)) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        state_reg   <= ST_GAP;
                        gap_cnt_reg <= '0;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        state_reg   <= ST_IDLE;
                        gap_cnt_reg <= '0;
                        busy_reg    <= 1'b0;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + GW'(1);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign READY     = (state_reg == ST_IDLE);
    assign SDATA     = sdata_reg;
    assign SHIFT_STB = tick;
    assign ENdin     = endin_reg;
    assign LATCH     = latch_reg;
    assign BUSY      = busy_reg;
    assign DONE      = done_reg;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_seq_ctrl
// Two instances: dut_a (WIDTH=8, CLK_DIV=2, GAP_CYCLES=2) and dut_b
// (WIDTH=8, CLK_DIV=1, GAP_CYCLES=0). Each has a frame-level model that derives
// the expected outputs of every cycle from the accept cycle, the word and any
// abort cycle; directed tests add hand-computed literal checks on top.
// Output vectors are packed as {READY,SDATA,SHIFT_STB,ENdin,LATCH,DONE,BUSY}.
// -----------------------------------------------------------------------------
module tb_shift_seq_ctrl;

    localparam logic [6:0] IDLE_VEC = 7'b1000000;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // DUT A signals
    logic       a_rst, a_valid, a_abort;
    logic [7:0] a_din;
    logic       a_ready, a_sdata, a_stb, a_endin, a_latch, a_busy, a_done;
    // DUT B signals
    logic       b_rst, b_valid, b_abort;
    logic [7:0] b_din;
    logic       b_ready, b_sdata, b_stb, b_endin, b_latch, b_busy, b_done;

    shift_seq_ctrl #(.WIDTH(8), .CLK_DIV(2), .GAP_CYCLES(2)) dut_a (
        .CLK(CLK), .RST(a_rst), .DATA_IN(a_din), .VALID(a_valid), .READY(a_ready),
        .ABORT(a_abort), .SDATA(a_sdata), .SHIFT_STB(a_stb), .ENdin(a_endin),
        .LATCH(a_latch), .BUSY(a_busy), .DONE(a_done)
    );

    shift_seq_ctrl #(.WIDTH(8), .CLK_DIV(1), .GAP_CYCLES(0)) dut_b (
        .CLK(CLK), .RST(b_rst), .DATA_IN(b_din), .VALID(b_valid), .READY(b_ready),
        .ABORT(b_abort), .SDATA(b_sdata), .SHIFT_STB(b_stb), .ENdin(b_endin),
        .LATCH(b_latch), .BUSY(b_busy), .DONE(b_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // i-th bit sent on the wire for word w.
    function automatic logic ord_bit(input logic [7:0] w, input int i);
`ifdef SHIFT_SEQ_LSB_FIRST_EN
        return w[i];
`else
        return w[7-i];
`endif
    endfunction

    // Expected outputs in cycle c for a frame accepted in cycle t (t<0: none),
    // aborted in cycle ab (ab<0: not aborted), divider d, gap g.
    function automatic logic [6:0] model(input int c, input int t, input int ab,
                                         input logic [7:0] w, input int d, input int g);
        int k;
        int ns;
        k  = c - t;
        ns = 8 * d;
        if (t < 0) return IDLE_VEC;
        if (ab >= 0 && c > ab) return IDLE_VEC;
        if (k >= 1 && k <= ns)
            return {1'b0, ord_bit(w, (k - 1) / d), (k % d) == 0, 1'b1, 1'b0, 1'b0, 1'b1};
        if (k == ns + 1) return 7'b0000111;
        if (k > ns + 1 && k <= ns + 1 + g) return 7'b0000001;
        return IDLE_VEC;
    endfunction

    // ---------------- DUT A model, compare and recorder ----------------
    int         a_t = -1, a_ab = -1;
    logic [7:0] a_w = '0;
    logic [6:0] a_exp;
    logic       a_prev_rdy = 1'b1;
    logic       a_bits[$];
    int         a_latch_cyc[$];
    int         a_rdy_cyc[$];

    always @(negedge CLK) begin
        if (a_rst) begin
            a_t   = -1;
            a_ab  = -1;
            a_exp = IDLE_VEC;
        end else begin
            a_exp = model(cyc, a_t, a_ab, a_w, 2, 2);
        end
        check("A_outputs", {a_ready, a_sdata, a_stb, a_endin, a_latch, a_done, a_busy}, a_exp);
        if (a_stb) a_bits.push_back(a_sdata);
        if (a_latch) a_latch_cyc.push_back(cyc);
        if (a_ready && !a_prev_rdy) a_rdy_cyc.push_back(cyc);
        a_prev_rdy = a_ready;
        if (!a_rst) begin
            if (a_abort && a_t >= 0 && a_ab < 0 && (cyc - a_t) >= 1 && (cyc - a_t) <= 17)
                a_ab = cyc;
            if (a_valid && a_exp[6]) begin
                a_t  = cyc;
                a_ab = -1;
                a_w  = a_din;
            end
        end
    end

    // ---------------- DUT B model, compare and recorder ----------------
    int         b_t = -1, b_ab = -1;
    logic [7:0] b_w = '0;
    logic [6:0] b_exp;
    logic       b_prev_rdy = 1'b1;
    int         b_strobes = 0;
    int         b_latch_cyc[$];
    int         b_rdy_cyc[$];

    always @(negedge CLK) begin
        if (b_rst) begin
            b_t   = -1;
            b_ab  = -1;
            b_exp = IDLE_VEC;
        end else begin
            b_exp = model(cyc, b_t, b_ab, b_w, 1, 0);
        end
        check("B_outputs", {b_ready, b_sdata, b_stb, b_endin, b_latch, b_done, b_busy}, b_exp);
        if (b_stb) b_strobes++;
        if (b_latch) b_latch_cyc.push_back(cyc);
        if (b_ready && !b_prev_rdy) b_rdy_cyc.push_back(cyc);
        b_prev_rdy = b_ready;
        if (!b_rst) begin
            if (b_abort && b_t >= 0 && b_ab < 0 && (cyc - b_t) >= 1 && (cyc - b_t) <= 9)
                b_ab = cyc;
            if (b_valid && b_exp[6]) begin
                b_t  = cyc;
                b_ab = -1;
                b_w  = b_din;
            end
        end
    end

    // Offer a word to DUT A or B and return the accept cycle (-1 on timeout).
    // Returns #1 after the edge that ends the accept cycle.
    task automatic send(input bit sel_b, input logic [7:0] w, output int t_acc);
        t_acc = -1;
        if (sel_b) begin b_din = w; b_valid = 1'b1; end
        else       begin a_din = w; a_valid = 1'b1; end
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (sel_b ? b_ready : a_ready) begin
                t_acc = cyc;
                break;
            end
        end
        @(posedge CLK);
        #1;
        if (sel_b) b_valid = 1'b0;
        else       a_valid = 1'b0;
        if (t_acc < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got no READY expected accept within 100 cycles");
        end
    endtask

    task automatic clear_rec();
        a_bits.delete();
        a_latch_cyc.delete();
        a_rdy_cyc.delete();
    endtask

    function automatic logic [7:0] bits_word();
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < 8 && i < a_bits.size(); i++) v[7-i] = a_bits[i];
        return v;
    endfunction

    int t1, t2;

    initial begin
        a_rst = 1'b1; a_valid = 1'b0; a_abort = 1'b0; a_din = '0;
        b_rst = 1'b1; b_valid = 1'b0; b_abort = 1'b0; b_din = '0;
        repeat (3) @(posedge CLK);
        #1;
        a_rst = 1'b0;
        b_rst = 1'b0;
        @(negedge CLK);
        check("reset_A", {a_ready, a_sdata, a_stb, a_endin, a_latch, a_done, a_busy}, IDLE_VEC);
        check("reset_B", {b_ready, b_sdata, b_stb, b_endin, b_latch, b_done, b_busy}, IDLE_VEC);
        @(posedge CLK);
        #1;

        // Single frame 8'hA5: strobes at T+2..T+16, LATCH at T+17, READY at T+20.
        clear_rec();
        send(1'b0, 8'hA5, t1);
        repeat (24) @(posedge CLK);
        #1;
        check("single_nbits", a_bits.size(), 8);
        check("single_sdata", bits_word(), 8'hA5);
        check("single_latch_ofs", (a_latch_cyc.size() > 0) ? a_latch_cyc[0] - t1 : -1, 17);
        check("single_ready_ofs", (a_rdy_cyc.size() > 0) ? a_rdy_cyc[0] - t1 : -1, 20);

        // Back-to-back 8'h3C then 8'hFF with VALID held.
        clear_rec();
        send(1'b0, 8'h3C, t1);
        send(1'b0, 8'hFF, t2);
        repeat (24) @(posedge CLK);
        #1;
        check("b2b_accept_gap", t2 - t1, 20);
        check("b2b_nlatch", a_latch_cyc.size(), 2);
        check("b2b_latch_gap", (a_latch_cyc.size() > 1) ? a_latch_cyc[1] - a_latch_cyc[0] : -1, 20);
        check("b2b_sdata_2nd", (a_bits.size() == 16) ? {a_bits[8], a_bits[9], a_bits[10], a_bits[11],
              a_bits[12], a_bits[13], a_bits[14], a_bits[15]} : 8'h00, 8'hFF);

        // Abort in the 3rd strobe cycle (T+6).
        clear_rec();
        send(1'b0, 8'h5A, t1);
        repeat (5) @(posedge CLK);
        #1 a_abort = 1'b1;
        @(posedge CLK);
        #1 a_abort = 1'b0;
        repeat (24) @(posedge CLK);
        #1;
        check("abort_nstb", a_bits.size(), 3);
        check("abort_nlatch", a_latch_cyc.size(), 0);
        check("abort_ready_ofs", (a_rdy_cyc.size() > 0) ? a_rdy_cyc[0] - t1 : -1, 7);

        // Abort coinciding with the final strobe (T+16): LATCH suppressed.
        clear_rec();
        send(1'b0, 8'hC3, t1);
        repeat (15) @(posedge CLK);
        #1 a_abort = 1'b1;
        @(posedge CLK);
        #1 a_abort = 1'b0;
        repeat (24) @(posedge CLK);
        #1;
        check("abort_last_nstb", a_bits.size(), 8);
        check("abort_last_nlatch", a_latch_cyc.size(), 0);
        check("abort_last_ready_ofs", (a_rdy_cyc.size() > 0) ? a_rdy_cyc[0] - t1 : -1, 17);

        // Asynchronous reset mid-SHIFT: outputs drop before the next edge.
        clear_rec();
        send(1'b0, 8'h96, t1);
        repeat (3) @(posedge CLK);
        #2 a_rst = 1'b1;
        #1;
        check("async_reset", {a_ready, a_sdata, a_stb, a_endin, a_latch, a_done, a_busy}, IDLE_VEC);
        @(posedge CLK);
        #1 a_rst = 1'b0;
        repeat (24) @(posedge CLK);
        #1;
        check("async_reset_nlatch", a_latch_cyc.size(), 0);

        // Bit order with a one-hot word.
        clear_rec();
        send(1'b0, 8'h01, t1);
        repeat (24) @(posedge CLK);
        #1;
`ifdef SHIFT_SEQ_LSB_FIRST_EN
        check("order_sdata", bits_word(), 8'h80);
`else
        check("order_sdata", bits_word(), 8'h01);
`endif

        // Edge parameters on dut_b: CLK_DIV=1, GAP_CYCLES=0, 8'h81.
        b_strobes = 0;
        send(1'b1, 8'h81, t1);
        repeat (16) @(posedge CLK);
        #1;
        check("edge_nstb", b_strobes, 8);
        check("edge_latch_ofs", (b_latch_cyc.size() > 0) ? b_latch_cyc[0] - t1 : -1, 9);
        check("edge_ready_ofs", (b_rdy_cyc.size() > 0) ? b_rdy_cyc[0] - t1 : -1, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Sequencer for the serial shift-register chain.
- Accepts a parallel word over a valid/ready handshake and serializes it onto SDATA with an enable window (ENdin) and per-bit shift strobes.
- Issues a one-cycle LATCH pulse after the last bit, then enforces an inter-frame gap before accepting the next word.
- Sits between the word source (top-level pattern logic) and the shift-register datapath.

Parameters:
- WIDTH, 16, bits per frame (>=2)
- CLK_DIV, 4, CLK cycles per serial bit (>=1)
- GAP_CYCLES, 2, idle cycles after LATCH before READY returns (>=0)

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous reset, active-high
- DATA_IN  in  WIDTH  word to serialize
- VALID  in  1  DATA_IN valid
- READY  out  1  block can accept a word
- ABORT  in  1  synchronous frame cancel
- SDATA  out  1  serial data bit to chain
- SHIFT_STB  out  1  one-cycle strobe; chain samples SDATA on it
- ENdin  out  1  high for the whole shift window
- LATCH  out  1  one-cycle parallel-latch pulse after last bit
- BUSY  out  1  state != IDLE
- DONE  out  1  one-cycle pulse, same cycle as LATCH

Behaviour:
- Reset values: READY=1; SDATA, SHIFT_STB, ENdin, LATCH, BUSY and DONE all 0. State is IDLE; all counters and the shadow register are 0.
- All outputs are registered, except READY, which is the decode of state==IDLE.
- States: IDLE, SHIFT, LATCH, GAP.
- IDLE:
  - READY=1.
  - When VALID&READY in cycle T, DATA_IN is captured into the shadow register, bit_cnt=0, div_cnt=0, and the next state is SHIFT.
  - VALID without READY is ignored; the source holds.
- SHIFT (cycles T+1 .. T+WIDTH*CLK_DIV):
  - ENdin=1.
  - SDATA = shadow[WIDTH-1-bit_cnt] (MSB first).
  - div_cnt counts 0..CLK_DIV-1. SHIFT_STB=1 in the cycle where div_cnt==CLK_DIV-1; at that cycle bit_cnt increments.
  - With CLK_DIV=1, SHIFT_STB is high every SHIFT cycle.
  - After the strobe for bit_cnt==WIDTH-1, the next state is LATCH.
- LATCH (cycle T+WIDTH*CLK_DIV+1):
  - LATCH=1, DONE=1, ENdin=0, SDATA=0.
  - Next state is GAP if GAP_CYCLES>0, else IDLE.
- GAP: gap_cnt runs GAP_CYCLES cycles with all strobes 0, then IDLE.
- READY returns at cycle T+WIDTH*CLK_DIV+2+GAP_CYCLES. Back-to-back VALID is accepted that same cycle.
- ABORT:
  - Sampled in SHIFT or LATCH; the next state is IDLE.
  - In the abort cycle, the registered outputs of the following cycle are all 0: no LATCH, no DONE, no further SHIFT_STB.
  - ABORT in IDLE or GAP is ignored.
  - ABORT and the final SHIFT_STB in the same cycle: the abort wins and LATCH is suppressed.
- Reset mid-frame: all outputs drop asynchronously to their reset values. The partial frame is discarded and no LATCH is issued.
- Counter widths:
  - div_cnt: $clog2(CLK_DIV) bits, minimum 1.
  - bit_cnt: $clog2(WIDTH) bits.
  - gap_cnt: $clog2(GAP_CYCLES+1) bits.
  - No wrap-around beyond terminal counts; counters reset to 0 on entry to each state.

Optional Feature:
- Macro SHIFT_SEQ_LSB_FIRST_EN.
- When defined: SDATA = shadow[bit_cnt], LSB first. All timing is identical.
- When undefined: MSB first, as in Behaviour.

Decomposition:
- Shared package shift_seq_pkg:
  - State encoding constants: IDLE=2'd0, SHIFT=2'd1, LATCH=2'd2, GAP=2'd3.
  - Default parameter constants.
  - A clog2-with-minimum-1 helper.
- One sub-module, shift_tick_gen:
  - Parameter CLK_DIV; inputs CLK, RST, clear, run; output tick.
  - Owns div_cnt and generates SHIFT_STB.
- FSM, bit counter, gap counter and shadow register stay in shift_seq_ctrl.

Test Plan (WIDTH=8, CLK_DIV=2, GAP_CYCLES=2 unless noted):
- Reset:
  - Stimulus: hold RST=1, then release.
  - Required: READY=1, all other outputs 0. RST asserted asynchronously mid-SHIFT forces the same values before the next edge.
- Single frame:
  - Stimulus: VALID with DATA_IN=8'hA5, accepted at T.
  - Required:
    - ENdin high T+1..T+16.
    - SHIFT_STB at T+2,4,..,16.
    - SDATA sequence sampled at strobes = 1,0,1,0,0,1,0,1.
    - LATCH and DONE at T+17.
    - READY at T+20.
- Back-to-back:
  - Stimulus: words 8'h3C then 8'hFF with VALID held.
  - Required: second accept exactly at T+20; two LATCH pulses 20 cycles apart.
- Abort:
  - Stimulus: ABORT at the 3rd SHIFT_STB cycle.
  - Required: next cycle IDLE (READY=1, ENdin=0); no LATCH or DONE; no further SHIFT_STB.
- Edge parameters:
  - Stimulus: CLK_DIV=1, GAP_CYCLES=0, DATA_IN=8'h81.
  - Required: SHIFT_STB every cycle T+1..T+8; LATCH at T+9; READY at T+10.
- Optional feature:
  - Stimulus: SHIFT_SEQ_LSB_FIRST_EN defined, DATA_IN=8'h01.
  - Required: SDATA=1 at the first strobe, 0 for the remaining seven.
